// File: rtl/dmem_arbiter_if.sv
// Bundled requester and data-memory signals for dmem_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the memory.
interface dmem_arbiter_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [DM_ADDRESS-1:0] m0_addr;
    logic [DATA_W-1:0]     m0_wdata;
    logic [2:0]            m0_funct3;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_W-1:0]     m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [DM_ADDRESS-1:0] m1_addr;
    logic [DATA_W-1:0]     m1_wdata;
    logic [2:0]            m1_funct3;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_W-1:0]     m1_rdata;

    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [2:0]            Funct3;
    logic [DATA_W-1:0]     rd;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_funct3,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_funct3,
        input  rd,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output MemRead, MemWrite, a, wd, Funct3
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_funct3,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_funct3,
        output rd,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  MemRead, MemWrite, a, wd, Funct3
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: grant in IDLE, one-cycle access, then completion pulse.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module dmem_arbiter #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic                  id;
    logic                  win_c;
    logic                  any_req_c;
    logic                  sel_we_c;
    logic [DM_ADDRESS-1:0] sel_addr_c;
    logic [DATA_W-1:0]     sel_wdata_c;
    logic [2:0]            sel_funct3_c;

`ifdef DMEM_ARB_RR_EN
    // Holds the requester that wins the next tie; flips to the loser on every grant.
    logic rr_ptr;

    always_comb begin
        win_c = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            win_c = rr_ptr;
        end else begin
            win_c = bus.m1_req;
        end
    end
`else
    always_comb begin
        win_c = !bus.m0_req;
    end
`endif

    always_comb begin
        any_req_c    = bus.m0_req || bus.m1_req;
        sel_we_c     = win_c ? bus.m1_we     : bus.m0_we;
        sel_addr_c   = win_c ? bus.m1_addr   : bus.m0_addr;
        sel_wdata_c  = win_c ? bus.m1_wdata  : bus.m0_wdata;
        sel_funct3_c = win_c ? bus.m1_funct3 : bus.m0_funct3;
    end

    // Grants are combinational in the IDLE cycle and forced low while reset is held.
    assign bus.m0_gnt = (state == IDLE) && !reset && bus.m0_req && !win_c;
    assign bus.m1_gnt = (state == IDLE) && !reset && bus.m1_req &&  win_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            id            <= 1'b0;
            bus.MemRead   <= 1'b0;
            bus.MemWrite  <= 1'b0;
            bus.a         <= '0;
            bus.wd        <= '0;
            bus.Funct3    <= 3'd0;
            bus.m0_rvalid <= 1'b0;
            bus.m1_rvalid <= 1'b0;
            bus.m0_rdata  <= '0;
            bus.m1_rdata  <= '0;
`ifdef DMEM_ARB_RR_EN
            rr_ptr        <= 1'b0;
`endif
        end else begin
            bus.MemRead   <= 1'b0;
            bus.MemWrite  <= 1'b0;
            bus.m0_rvalid <= 1'b0;
            bus.m1_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        id           <= win_c;
                        bus.a        <= sel_addr_c;
                        bus.wd       <= sel_wdata_c;
                        bus.Funct3   <= sel_funct3_c;
                        bus.MemRead  <= !sel_we_c;
                        bus.MemWrite <= sel_we_c;
`ifdef DMEM_ARB_RR_EN
                        rr_ptr       <= !win_c;
`endif
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    // rd is valid only while MemRead is high, so capture it on this edge.
                    if (bus.MemRead) begin
                        if (id) begin
                            bus.m1_rdata <= bus.rd;
                        end else begin
                            bus.m0_rdata <= bus.rd;
                        end
                    end
                    bus.m0_rvalid <= !id;
                    bus.m1_rvalid <= id;
                    state         <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with hand-computed expectations.
// Arbitration expectations follow DMEM_ARB_RR_EN when the bench is built with it.
module tb_dmem_arbiter;
    localparam int unsigned DM_ADDRESS = 9;
    localparam int unsigned DATA_W     = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [8:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3);
        bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
        bus.m0_wdata = wdata; bus.m0_funct3 = f3;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [8:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3);
        bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr;
        bus.m1_wdata = wdata; bus.m1_funct3 = f3;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic exp_m0;
        logic exp_m1;

        set_m0(1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
        set_m1(1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
        bus.rd = 32'h0;
        reset  = 1'b1;
        cyc();
        cyc();

        // Reset values
        chk("rst_memread",  bus.MemRead,   1'b0);
        chk("rst_memwrite", bus.MemWrite,  1'b0);
        chk("rst_a",        bus.a,         9'h000);
        chk("rst_wd",       bus.wd,        32'h0);
        chk("rst_funct3",   bus.Funct3,    3'd0);
        chk("rst_m0_gnt",   bus.m0_gnt,    1'b0);
        chk("rst_m1_gnt",   bus.m1_gnt,    1'b0);
        chk("rst_m0_rv",    bus.m0_rvalid, 1'b0);
        chk("rst_m1_rv",    bus.m1_rvalid, 1'b0);
        chk("rst_m0_rdata", bus.m0_rdata,  32'h0);
        chk("rst_m1_rdata", bus.m1_rdata,  32'h0);
        reset = 1'b0;
        cyc();
        chk("idle_no_gnt", bus.m0_gnt | bus.m1_gnt, 1'b0);

        // m0 read: gnt N, access N+1, rvalid N+2
        set_m0(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
        bus.rd = 32'hDEADBEEF;
        #2;
        chk("rd0_m0_gnt", bus.m0_gnt, 1'b1);
        chk("rd0_m1_gnt", bus.m1_gnt, 1'b0);
        chk("rd0_n_memrd", bus.MemRead, 1'b0);
        cyc();
        set_m0(1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
        #2;
        chk("rd0_memrd", bus.MemRead, 1'b1);
        chk("rd0_memwr", bus.MemWrite, 1'b0);
        chk("rd0_a", bus.a, 9'h010);
        chk("rd0_f3", bus.Funct3, 3'b010);
        chk("rd0_early_rv", bus.m0_rvalid, 1'b0);
        cyc();
        #2;
        chk("rd0_rvalid", bus.m0_rvalid, 1'b1);
        chk("rd0_m1_rv", bus.m1_rvalid, 1'b0);
        chk("rd0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        chk("rd0_resp_memrd", bus.MemRead, 1'b0);
        chk("rd0_hold_a", bus.a, 9'h010);
        cyc();
        chk("rd0_rv_drop", bus.m0_rvalid, 1'b0);

        // m1 write: one-cycle MemWrite, rvalid pulse, rdata untouched
        bus.rd = 32'hCAFEF00D;
        set_m1(1'b1, 1'b1, 9'h1FC, 32'h12345678, 3'b000);
        #2;
        chk("wr1_m1_gnt", bus.m1_gnt, 1'b1);
        chk("wr1_m0_gnt", bus.m0_gnt, 1'b0);
        cyc();
        set_m1(1'b0, 1'b0, 9'h000, 32'h0, 3'd7);
        #2;
        chk("wr1_memwr", bus.MemWrite, 1'b1);
        chk("wr1_memrd", bus.MemRead, 1'b0);
        chk("wr1_a", bus.a, 9'h1FC);
        chk("wr1_wd", bus.wd, 32'h12345678);
        chk("wr1_f3", bus.Funct3, 3'b000);
        cyc();
        #2;
        chk("wr1_memwr_off", bus.MemWrite, 1'b0);
        chk("wr1_rvalid", bus.m1_rvalid, 1'b1);
        chk("wr1_m0_rv", bus.m0_rvalid, 1'b0);
        chk("wr1_m1_rdata", bus.m1_rdata, 32'h0);
        chk("wr1_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        cyc();

        // m1 read with a one-cycle m0 pulse during ACCESS that must be ignored
        bus.rd = 32'h0BADF00D;
        set_m1(1'b1, 1'b0, 9'h044, 32'h0, 3'b100);
        #2;
        chk("pl_m1_gnt", bus.m1_gnt, 1'b1);
        cyc();
        set_m1(1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
        set_m0(1'b1, 1'b1, 9'h0AA, 32'h55555555, 3'b010);
        #2;
        chk("pl_m0_gnt_acc", bus.m0_gnt, 1'b0);
        chk("pl_memrd", bus.MemRead, 1'b1);
        chk("pl_a", bus.a, 9'h044);
        cyc();
        set_m0(1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
        #2;
        chk("pl_m1_rv", bus.m1_rvalid, 1'b1);
        chk("pl_m1_rdata", bus.m1_rdata, 32'h0BADF00D);
        chk("pl_m0_gnt_resp", bus.m0_gnt, 1'b0);
        cyc();
        chk("pl_m0_gnt_idle", bus.m0_gnt, 1'b0);
        cyc();
        chk("pl_no_memrd", bus.MemRead, 1'b0);
        chk("pl_no_memwr", bus.MemWrite, 1'b0);
        chk("pl_hold_a", bus.a, 9'h044);

        // Reset during ACCESS of an m1 read
        set_m1(1'b1, 1'b0, 9'h088, 32'h0, 3'b010);
        #2;
        chk("ra_m1_gnt", bus.m1_gnt, 1'b1);
        cyc();
        set_m1(1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
        #2;
        chk("ra_memrd", bus.MemRead, 1'b1);
        reset = 1'b1;
        #1;
        chk("ra_memrd0", bus.MemRead, 1'b0);
        chk("ra_memwr0", bus.MemWrite, 1'b0);
        chk("ra_a0", bus.a, 9'h000);
        chk("ra_wd0", bus.wd, 32'h0);
        chk("ra_f3_0", bus.Funct3, 3'd0);
        chk("ra_m1_rdata0", bus.m1_rdata, 32'h0);
        chk("ra_gnt0", bus.m0_gnt | bus.m1_gnt, 1'b0);
        cyc();
        reset = 1'b0;
        #2;
        chk("ra_m1_rv_a", bus.m1_rvalid, 1'b0);
        cyc();
        chk("ra_m1_rv_b", bus.m1_rvalid, 1'b0);
        bus.rd = 32'hA5A5A5A5;
        set_m0(1'b1, 1'b0, 9'h020, 32'h0, 3'b001);
        #2;
        chk("ra_next_gnt", bus.m0_gnt, 1'b1);
        cyc();
        set_m0(1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
        #2;
        chk("ra_next_memrd", bus.MemRead, 1'b1);
        chk("ra_next_a", bus.a, 9'h020);
        cyc();
        #2;
        chk("ra_next_rv", bus.m0_rvalid, 1'b1);
        chk("ra_next_rdata", bus.m0_rdata, 32'hA5A5A5A5);
        cyc();

        // Both requesters held high from a fresh reset
        do_reset();
        set_m0(1'b1, 1'b0, 9'h100, 32'h0, 3'b010);
        set_m1(1'b1, 1'b0, 9'h180, 32'h0, 3'b010);
        for (int k = 0; k < 12; k++) begin
            #2;
            exp_m0 = 1'b0;
            exp_m1 = 1'b0;
            if (k % 3 == 0) begin
`ifdef DMEM_ARB_RR_EN
                exp_m0 = ((k / 3) % 2 == 0);
                exp_m1 = ((k / 3) % 2 == 1);
`else
                exp_m0 = 1'b1;
`endif
            end
            chk($sformatf("arb_m0_gnt_%0d", k), bus.m0_gnt, exp_m0);
            chk($sformatf("arb_m1_gnt_%0d", k), bus.m1_gnt, exp_m1);
            chk($sformatf("arb_rv_excl_%0d", k), bus.m0_rvalid & bus.m1_rvalid, 1'b0);
            cyc();
        end
        set_m0(1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
        set_m1(1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
        #2;
        chk("arb_drain_gnt", bus.m0_gnt | bus.m1_gnt, 1'b0);
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DM_ADDRESS, default 9, data memory byte-address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m0_req  input  1  requester 0 (core load/store) access request; held high until m0_gnt.
REQ-006 m0_we  input  1  requester 0 write (1) / read (0).
REQ-007 m0_addr  input  DM_ADDRESS  requester 0 byte address.
REQ-008 m0_wdata  input  DATA_W  requester 0 store data.
REQ-009 m0_funct3  input  3  requester 0 access size/sign code (LB/LH/LW/LBU/SB/SH/SW encoding).
REQ-010 m0_gnt  output  1  one-cycle pulse: requester 0 command accepted.
REQ-011 m0_rvalid  output  1  one-cycle pulse: requester 0 access complete; m0_rdata valid for reads.
REQ-012 m0_rdata  output  DATA_W  requester 0 load data.
REQ-013 m1_req, m1_we, m1_addr, m1_wdata, m1_funct3, m1_gnt, m1_rvalid, m1_rdata: requester 1 (DMA/debug), same directions, widths and meanings as the m0_* ports.
REQ-014 MemRead  output  1  data memory read enable.
REQ-015 MemWrite  output  1  data memory write enable.
REQ-016 a  output  DM_ADDRESS  data memory address.
REQ-017 wd  output  DATA_W  data memory write data.
REQ-018 Funct3  output  3  data memory access code.
REQ-019 rd  input  DATA_W  data memory read data, valid in the same cycle MemRead is high.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-021 In IDLE with at least one req high, the block SHALL select a winner, assert its gnt combinationally in that cycle, latch the winner's we/addr/wdata/funct3 and winner ID, and move to ACCESS.
REQ-022 In IDLE with no req high, the block SHALL stay in IDLE with both gnt low.
REQ-023 In ACCESS, the block SHALL drive a/wd/Funct3 from the latched command, assert exactly one of MemRead (we=0) or MemWrite (we=1) for exactly one cycle, capture rd into the winner's rdata register on a read, and move to RESP.
REQ-024 In RESP, the block SHALL pulse the winner's rvalid for one cycle, for both reads and writes, and return to IDLE.
REQ-025 Command-to-completion latency: gnt in cycle N, memory access in N+1, rvalid in N+2; the next gnt is earliest in cycle N+3.
REQ-026 Outside ACCESS, MemRead and MemWrite SHALL be 0, and a, wd and Funct3 SHALL hold their last latched values.
REQ-027 rdata of each requester SHALL hold its last captured value until that requester's next read completes; writes SHALL NOT modify it.
REQ-028 At most one gnt and at most one rvalid SHALL be high in any cycle.
REQ-029 A req dropped before gnt SHALL be ignored with no memory access; req changes after gnt SHALL NOT affect the in-flight command.

Reset
REQ-030 On reset assertion, the FSM SHALL go to IDLE immediately, including mid-ACCESS or mid-RESP; the in-flight access SHALL be abandoned without rvalid.
REQ-031 Reset values: MemRead=0, MemWrite=0, a=0, wd=0, Funct3=0, both gnt=0, both rvalid=0, both rdata=0, round-robin pointer=requester 0.

Configuration
REQ-032 Macro DMEM_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests the winner is the requester not granted most recently; the pointer updates on each gnt; after reset requester 0 wins the first tie.
REQ-033 Macro DMEM_ARB_RR_EN undefined: fixed priority; requester 0 always wins a tie; the pointer logic is absent.

Verification
REQ-034 Reset, m0 read addr 0x010 funct3 010, rd=0xDEADBEEF -> m0_gnt cycle N, MemRead=1 with a=0x010 in N+1, m0_rvalid=1 and m0_rdata=0xDEADBEEF in N+2.
REQ-035 m1 write addr 0x1FC wdata 0x12345678 funct3 000 -> MemWrite=1 for exactly one cycle with a=0x1FC, wd=0x12345678, Funct3=000; m1_rvalid pulses; m1_rdata is unchanged.
REQ-036 m0_req and m1_req held high continuously with DMEM_ARB_RR_EN -> grants alternate m0, m1, m0, m1 at 3-cycle spacing; without the macro -> m0 granted every time and m1 never granted.
REQ-037 Reset asserted during ACCESS of an m1 read -> all outputs 0 in the same cycle, no m1_rvalid, and the next request after reset is granted from IDLE.
REQ-038 m0_req pulsed high for one cycle while the FSM is in ACCESS serving m1, then dropped -> no m0_gnt and no extra memory access.
